axi_lite_arbiter: RTL

- Round-robin arbiter that shares one downstream AXI-lite slave port between two AXI-lite masters: master 0 is instruction fetch, master 1 is load/store.
- Arbitrates per whole transaction: one read (AR+R) or one write (AW+W+B) at a time, never interleaved.
- Sits between the core's fetch/LSU ports and the address-decoding crossbar, replacing fixed-priority master selection with fair arbitration.

---
 rtl/axi_lite_arbiter.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_arbiter.sv
// ============================================================================
// Module      : axi_lite_arbiter
// Description : Round-robin, whole-transaction arbiter sharing one AXI-lite
//               slave port between instruction fetch (m0) and load/store (m1).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_lite_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  // master 0 (instruction fetch)
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_rresp,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  input  logic [ADDR_W-1:0] m0_awaddr,
  input  logic              m0_awvalid,
  output logic              m0_awready,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [STRB_W-1:0] m0_wstrb,
  input  logic              m0_wvalid,
  output logic              m0_wready,
  output logic              m0_bresp,
  output logic              m0_bvalid,
  input  logic              m0_bready,
  // master 1 (load/store)
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_rresp,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  input  logic [ADDR_W-1:0] m1_awaddr,
  input  logic              m1_awvalid,
  output logic              m1_awready,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [STRB_W-1:0] m1_wstrb,
  input  logic              m1_wvalid,
  output logic              m1_wready,
  output logic              m1_bresp,
  output logic              m1_bvalid,
  input  logic              m1_bready,
  // downstream slave port
  output logic [ADDR_W-1:0] s_araddr,
  output logic              s_arvalid,
  input  logic              s_arready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              s_rresp,
  input  logic              s_rvalid,
  output logic              s_rready,
  output logic [ADDR_W-1:0] s_awaddr,
  output logic              s_awvalid,
  input  logic              s_awready,
  output logic [DATA_W-1:0] s_wdata,
  output logic [STRB_W-1:0] s_wstrb,
  output logic              s_wvalid,
  input  logic              s_wready,
  input  logic              s_bresp,
  input  logic              s_bvalid,
  output logic              s_bready
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_WR   = 3'd3,
    S_B    = 3'd4
  } state_t;

  state_t r_state;
  logic   r_grant;
  logic   r_last_grant;
  logic   r_aw_done;
  logic   r_w_done;

  // Arbitration decision, only consumed in IDLE
  logic w_req0, w_req1, w_pick, w_pick_rd;
  assign w_req0    = m0_arvalid | m0_awvalid;
  assign w_req1    = m1_arvalid | m1_awvalid;
  assign w_pick    = (w_req0 & w_req1) ? ~r_last_grant : w_req1;
  assign w_pick_rd = w_pick ? m1_arvalid : m0_arvalid;

  // Request side of the granted master
  logic [ADDR_W-1:0] w_araddr, w_awaddr;
  logic [DATA_W-1:0] w_wdata;
  logic [STRB_W-1:0] w_wstrb;
  logic w_arvalid, w_rready, w_awvalid, w_wvalid, w_bready;
  assign w_araddr  = r_grant ? m1_araddr  : m0_araddr;
  assign w_arvalid = r_grant ? m1_arvalid : m0_arvalid;
  assign w_rready  = r_grant ? m1_rready  : m0_rready;
  assign w_awaddr  = r_grant ? m1_awaddr  : m0_awaddr;
  assign w_awvalid = r_grant ? m1_awvalid : m0_awvalid;
  assign w_wdata   = r_grant ? m1_wdata   : m0_wdata;
  assign w_wstrb   = r_grant ? m1_wstrb   : m0_wstrb;
  assign w_wvalid  = r_grant ? m1_wvalid  : m0_wvalid;
  assign w_bready  = r_grant ? m1_bready  : m0_bready;

  always_comb begin
    s_araddr  = '0;
    s_arvalid = 1'b0;
    s_rready  = 1'b0;
    s_awaddr  = '0;
    s_awvalid = 1'b0;
    s_wdata   = '0;
    s_wstrb   = '0;
    s_wvalid  = 1'b0;
    s_bready  = 1'b0;
    unique case (r_state)
      S_AR: begin
        s_araddr  = w_araddr;
        s_arvalid = w_arvalid;
      end
      S_R:  s_rready = w_rready;
      S_WR: begin
        // A channel that already handshook must not issue a second beat
        s_awaddr  = w_awaddr;
        s_awvalid = w_awvalid & ~r_aw_done;
        s_wdata   = w_wdata;
        s_wstrb   = w_wstrb;
        s_wvalid  = w_wvalid & ~r_w_done;
      end
      S_B:  s_bready = w_bready;
      default: ;
    endcase
  end

  // Response side, before steering to the granted master
  logic [DATA_W-1:0] w_rdata;
  logic w_arready, w_rresp, w_rvalid, w_awready, w_wready, w_bresp, w_bvalid;
  assign w_arready = (r_state == S_AR) & s_arready;
  assign w_rvalid  = (r_state == S_R)  & s_rvalid;
  assign w_rdata   = (r_state == S_R)  ? s_rdata : '0;
  assign w_rresp   = (r_state == S_R)  & s_rresp;
  assign w_awready = (r_state == S_WR) & s_awready & ~r_aw_done;
  assign w_wready  = (r_state == S_WR) & s_wready & ~r_w_done;
  assign w_bvalid  = (r_state == S_B)  & s_bvalid;
  assign w_bresp   = (r_state == S_B)  & s_bresp;

  assign m0_arready = ~r_grant & w_arready;
  assign m0_rvalid  = ~r_grant & w_rvalid;
  assign m0_rdata   = r_grant ? '0 : w_rdata;
  assign m0_rresp   = ~r_grant & w_rresp;
  assign m0_awready = ~r_grant & w_awready;
  assign m0_wready  = ~r_grant & w_wready;
  assign m0_bvalid  = ~r_grant & w_bvalid;
  assign m0_bresp   = ~r_grant & w_bresp;

  assign m1_arready = r_grant & w_arready;
  assign m1_rvalid  = r_grant & w_rvalid;
  assign m1_rdata   = r_grant ? w_rdata : '0;
  assign m1_rresp   = r_grant & w_rresp;
  assign m1_awready = r_grant & w_awready;
  assign m1_wready  = r_grant & w_wready;
  assign m1_bvalid  = r_grant & w_bvalid;
  assign m1_bresp   = r_grant & w_bresp;

  logic w_aw_hs, w_w_hs;
  assign w_aw_hs = s_awvalid & s_awready;
  assign w_w_hs  = s_wvalid & s_wready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_aw_done    <= 1'b0;
      r_w_done     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req0 | w_req1) begin
            r_grant <= w_pick;
            r_state <= w_pick_rd ? S_AR : S_WR;
          end
        end
        S_AR: if (s_arvalid & s_arready) r_state <= S_R;
        S_R: begin
          if (s_rvalid & s_rready) begin
            r_state      <= S_IDLE;
            r_last_grant <= r_grant;
          end
        end
        S_WR: begin
          if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) begin
            r_state   <= S_B;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
          end else begin
            if (w_aw_hs) r_aw_done <= 1'b1;
            if (w_w_hs)  r_w_done  <= 1'b1;
          end
        end
        S_B: begin
          if (s_bvalid & s_bready) begin
            r_state      <= S_IDLE;
            r_last_grant <= r_grant;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
